// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//   Initiator side of the CSR set/clear bus. Takes one Zicsr request from the
//   execute stage, probes the addressed CSR (ack + old value, no side effect),
//   then issues at most one set/clear write pulse and returns the old value
//   (or an illegal-instruction flag) to the pipeline.
//
// Ports
//   clk_i, rst_i             clock / asynchronous active-low reset
//   req_*                    request from execute stage (valid/ready)
//   flush_i                  pipeline flush, drops the request in flight
//   csr_en_o/addr_o          CSR bus enable and address (PROBE and COMMIT only)
//   csr_set_o/csr_clear_o    write masks, non-zero only in COMMIT
//   csr_ack_i/csr_value_i    combinational ack and read value from the CSR
//   rsp_*                    response to the pipeline (valid/ready)
//   dbg_state_o              current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once rsp_valid_o rises, rsp_rdata_o/rsp_illegal_o stay constant
// until that transfer (or a flush) takes place.
// ---------------------------------------------------------------------------
module csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_rs1_data_i,
    input  logic [4:0]        req_src_idx_i,
    input  logic              flush_i,
    output logic              csr_en_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_set_o,
    output logic [XLEN-1:0]   csr_clear_o,
    input  logic              csr_ack_i,
    input  logic [XLEN-1:0]   csr_value_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_illegal_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;          // funct3[1:0]: 01 RW, 10 RS, 11 RC
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [4:0]        src_idx_q, src_idx_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              illegal_q, illegal_d;

    logic wr;
    logic probe_illegal;

    // RW forms always write; set/clear forms write only with a non-zero source index.
    assign wr            = (op_q == 2'b01) || (src_idx_q != 5'd0);
    assign probe_illegal = !csr_ack_i || (wr && (addr_q[ADDR_W-1 -: 2] == 2'b11));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        src_d       = src_q;
        src_idx_d   = src_idx_q;
        rdata_d     = rdata_q;
        illegal_d   = illegal_q;
        req_ready_o = 1'b0;
        csr_en_o    = 1'b0;
        csr_addr_o  = '0;
        csr_set_o   = '0;
        csr_clear_o = '0;
        rsp_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d      = req_funct3_i[1:0];
                    addr_d    = req_addr_i;
                    src_idx_d = req_src_idx_i;
                    src_d     = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_src_idx_i}
                                                : req_rs1_data_i;
                    rdata_d   = '0;
                    // funct3 000/100 are not CSR ops: answer illegal without touching the bus.
                    if (req_funct3_i[1:0] == 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        illegal_d = 1'b0;
                        state_d   = S_PROBE;
                    end
                end
            end
            S_PROBE: begin
                csr_en_o   = 1'b1;
                csr_addr_o = addr_q;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    illegal_d = probe_illegal;
                    rdata_d   = probe_illegal ? '0 : csr_value_i;
                    state_d   = (probe_illegal || !wr) ? S_RESP : S_COMMIT;
                end
            end
            S_COMMIT: begin
                csr_en_o   = 1'b1;
                csr_addr_o = addr_q;
                case (op_q)
                    2'b01: begin
                        csr_set_o   = src_q;
                        csr_clear_o = ~src_q;
                    end
                    2'b10:   csr_set_o   = src_q;
                    2'b11:   csr_clear_o = src_q;
                    default: ;
                endcase
                // The pulse above goes out even on flush; only the response is dropped.
                state_d = flush_i ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (flush_i || rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_rdata_o   = (state_q == S_RESP) ? rdata_q : '0;
    assign rsp_illegal_o = (state_q == S_RESP) && illegal_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            addr_q    <= '0;
            src_q     <= '0;
            src_idx_q <= 5'd0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            src_idx_q <= src_idx_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_access_ctrl
//   Bench for csr_access_ctrl. A small CSR bank answers the bus; a reference
//   model computes the Zicsr result of each request and pushes the expected
//   bus cycles and response into queues that independent monitors pop.
// ---------------------------------------------------------------------------
module tb_csr_access_ctrl;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 12;
  localparam int NCSR   = 6;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [2:0]        req_funct3_i = 3'd0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [XLEN-1:0]   req_rs1_data_i = '0;
  logic [4:0]        req_src_idx_i = 5'd0;
  logic              flush_i = 1'b0;
  logic              csr_en_o;
  logic [ADDR_W-1:0] csr_addr_o;
  logic [XLEN-1:0]   csr_set_o;
  logic [XLEN-1:0]   csr_clear_o;
  logic              csr_ack_i;
  logic [XLEN-1:0]   csr_value_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [XLEN-1:0]   rsp_rdata_o;
  logic              rsp_illegal_o;
  logic [1:0]        dbg_state_o;

  csr_access_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_rs1_data_i (req_rs1_data_i),
    .req_src_idx_i  (req_src_idx_i),
    .flush_i        (flush_i),
    .csr_en_o       (csr_en_o),
    .csr_addr_o     (csr_addr_o),
    .csr_set_o      (csr_set_o),
    .csr_clear_o    (csr_clear_o),
    .csr_ack_i      (csr_ack_i),
    .csr_value_i    (csr_value_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- CSR bank ----------------
  function automatic int csr_id(input logic [11:0] a);
    case (a)
      12'h300: return 0;   // mstatus
      12'h305: return 1;   // mtvec
      12'h340: return 2;   // mscratch
      12'h341: return 3;   // mepc
      12'hC00: return 4;   // cycle (read-only space)
      12'hF14: return 5;   // mhartid (read-only space)
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] csr_rst_val(input int id);
    case (id)
      0:       return 32'h0000_1880;
      4:       return 32'h0000_1234;
      5:       return 32'h0000_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [11:0] pick_addr(input int k);
    case (k)
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h340;
      3: return 12'h341;
      4: return 12'hC00;
      5: return 12'hF14;
      6: return 12'h7FF;
      default: return 12'h123;
    endcase
  endfunction

  logic [31:0] bank [NCSR];
  logic [31:0] ref_csr [NCSR];
  int bank_wid;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NCSR; i++) bank[i] <= csr_rst_val(i);
    end else if (csr_en_o) begin
      bank_wid = csr_id(csr_addr_o);
      if (bank_wid >= 0) bank[bank_wid] <= (bank[bank_wid] | csr_set_o) & ~csr_clear_o;
    end
  end

  always_comb begin
    csr_ack_i   = 1'b0;
    csr_value_i = '0;
    if (csr_en_o && csr_id(csr_addr_o) >= 0) begin
      csr_ack_i   = 1'b1;
      csr_value_i = bank[csr_id(csr_addr_o)];
    end
  end

  // ---------------- scoreboard ----------------
  logic [XLEN:0]                 exp_q[$];      // {illegal, rdata}
  int                            lat_q[$];
  logic [ADDR_W+2*XLEN-1:0]      bus_q[$];      // {addr, set, clear} per enable cycle
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- response ready generator ----------------
  bit rand_rdy  = 1'b1;
  bit force_rdy = 1'b0;
  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
    else          rsp_ready_i = force_rdy;
  end

  // ---------------- monitors ----------------
  int  cyc = 0;
  int  acc_cyc = 0;
  bit  in_rsp = 1'b0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      in_rsp = 1'b0;
    end else begin
      if (req_valid_i && req_ready_o) acc_cyc = cyc;

      if (csr_en_o) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_en", {csr_addr_o, csr_set_o, csr_clear_o}, '0);
          if (csr_en_o) begin n_checks++; n_fail++; $display("FAIL bus_extra_pulse: en=1 with nothing expected"); end
        end else begin
          check("bus_cycle", {csr_addr_o, csr_set_o, csr_clear_o}, bus_q.pop_front());
        end
      end

      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rsp_unexpected: got %0h expected none", {rsp_illegal_o, rsp_rdata_o});
        end else begin
          if (!in_rsp) check("rsp_latency", cyc - acc_cyc, lat_q[0]);
          check("rsp_data", {rsp_illegal_o, rsp_rdata_o}, exp_q[0]);
          in_rsp = 1'b1;
          if (rsp_ready_i || flush_i) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            in_rsp = 1'b0;
          end
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // fl: 0 none, 1 flush in PROBE, 2 flush in COMMIT, 3 flush in RESP
  task automatic send(input logic [2:0] f3, input logic [11:0] addr,
                      input logic [31:0] rs1, input logic [4:0] idx, input int fl);
    int w;
    int id;
    int lat;
    logic [31:0] src, old, setm, clrm, nv, rdata;
    logic known, acked, wr, ill, commit;
    w = 0;
    while (!req_ready_o && w < 300) begin
      @(posedge clk_i); #1; w++;
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    req_valid_i    = 1'b1;
    req_funct3_i   = f3;
    req_addr_i     = addr;
    req_rs1_data_i = rs1;
    req_src_idx_i  = idx;
    @(posedge clk_i); #1;
    req_valid_i    = 1'b0;
    req_funct3_i   = 3'($urandom);
    req_addr_i     = 12'($urandom);
    req_rs1_data_i = $urandom;
    req_src_idx_i  = 5'($urandom);

    // Zicsr semantics
    known = (f3 != 3'b000) && (f3 != 3'b100);
    id    = csr_id(addr);
    acked = (id >= 0);
    src   = f3[2] ? {27'd0, idx} : rs1;
    old   = acked ? ref_csr[id] : 32'h0;
    wr    = (f3[1:0] == 2'b01) || (idx != 5'd0);
    ill   = !known || !acked || (wr && addr[11:10] == 2'b11);
    commit = known && !ill && wr;
    setm = 32'h0; clrm = 32'h0; nv = old;
    case (f3[1:0])
      2'b01: begin setm = src; clrm = ~src; nv = src;        end
      2'b10: begin setm = src;              nv = old | src;  end
      2'b11: begin clrm = src;              nv = old & ~src; end
      default: ;
    endcase
    lat   = !known ? 1 : (commit ? 3 : 2);
    rdata = ill ? 32'h0 : old;

    if (known) bus_q.push_back({addr, 32'h0, 32'h0});
    if (commit && fl != 1) begin
      bus_q.push_back({addr, setm, clrm});
      ref_csr[id] = nv;
    end
    if (fl == 0 || fl == 3) begin
      exp_q.push_back({ill, rdata});
      lat_q.push_back(lat);
    end

    case (fl)
      1: begin
        flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
      end
      2: begin
        @(posedge clk_i); #1; flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
      end
      3: begin
        repeat (lat - 1) @(posedge clk_i);
        #1; flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || !req_ready_o) && w < 300) begin
      @(posedge clk_i); #1; w++;
    end
    if (w >= 300) check("drain_timeout", 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NCSR; i++) ref_csr[i] = csr_rst_val(i);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req_ready",   req_ready_o,   1);
    check("rst_rsp_valid",   rsp_valid_o,   0);
    check("rst_csr_en",      csr_en_o,      0);
    check("rst_masks",       {csr_addr_o, csr_set_o, csr_clear_o}, 0);
    check("rst_rsp_payload", {rsp_illegal_o, rsp_rdata_o}, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Directed Zicsr cases on mstatus and friends
    send(3'b010, 12'h300, 32'hDEAD_BEEF, 5'd0, 0);   // CSRRS x0: read only
    send(3'b001, 12'h300, 32'h0000_0008, 5'd5, 0);   // CSRRW: MIE=1
    send(3'b010, 12'h300, 32'h0,         5'd0, 0);   // read back
    send(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8, 0);   // CSRRCI uimm=8
    send(3'b010, 12'h300, 32'h0,         5'd0, 0);
    send(3'b001, 12'h7FF, 32'h1234_5678, 5'd1, 0);   // no ack
    send(3'b001, 12'hC00, 32'h1,         5'd1, 0);   // write to read-only space
    send(3'b010, 12'hC00, 32'h1,         5'd0, 0);   // read of read-only space is fine
    send(3'b110, 12'hF14, 32'h0,         5'd0, 0);   // CSRRSI uimm=0 on read-only: legal read
    send(3'b000, 12'h300, 32'h1,         5'd1, 0);   // unknown funct3
    send(3'b100, 12'h340, 32'h1,         5'd1, 0);
    send(3'b101, 12'h340, 32'h0,         5'd31, 0);  // CSRRWI
    send(3'b011, 12'h340, 32'h0000_000F, 5'd2, 0);   // CSRRC
    wait_drain();

    // Flush scenarios with the response side held off
    rand_rdy = 1'b0; force_rdy = 1'b0;
    @(posedge clk_i); #1;
    send(3'b001, 12'h340, 32'h0000_A5A5, 5'd3, 2);   // flush in COMMIT: write lands
    send(3'b001, 12'h340, 32'hFFFF_FFFF, 5'd3, 1);   // flush in PROBE: no write
    send(3'b010, 12'h340, 32'h0,         5'd0, 3);   // flush in RESP: dropped
    rand_rdy = 1'b1;
    send(3'b010, 12'h340, 32'h0,         5'd0, 0);   // expect 0xA5A5
    wait_drain();

    // Response back-pressure: held stable, no new request taken
    rand_rdy = 1'b0; force_rdy = 1'b0;
    @(posedge clk_i); #1;
    send(3'b010, 12'h300, 32'h0, 5'd0, 0);
    begin
      int w;
      w = 0;
      while (!rsp_valid_o && w < 20) begin @(negedge clk_i); w++; end
      if (!rsp_valid_o) check("hold_rsp_timeout", 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_req_ready", req_ready_o, 0);
      check("hold_rsp_valid", rsp_valid_o, 1);
    end
    force_rdy = 1'b1;
    wait_drain();
    force_rdy = 1'b0;
    rand_rdy  = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      send(3'($urandom_range(0, 7)), pick_addr($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 0);
    end
    wait_drain();

    for (int i = 0; i < NCSR; i++) check("csr_final_value", bank[i], ref_csr[i]);

    // Asynchronous reset in the middle of a COMMIT
    send(3'b001, 12'h340, 32'h0000_0F0F, 5'd4, 0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("rst_mid_csr_en",    csr_en_o,    0);
    check("rst_mid_req_ready", req_ready_o, 1);
    check("rst_mid_rsp_valid", rsp_valid_o, 0);
    exp_q.delete();
    lat_q.delete();
    bus_q.delete();
    for (int i = 0; i < NCSR; i++) ref_csr[i] = csr_rst_val(i);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    send(3'b010, 12'h300, 32'h0, 5'd0, 0);           // back to reset value 0x1880
    wait_drain();

    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_bus_q_empty", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
